// File: rtl/refresh_cmd_arbiter.sv
// refresh_cmd_arbiter: shares the DRAM command slot between the refresher and NBANKS bank machines
// Ports: sys_clk/sys_rst (async active-high); ref_* refresher request, grant and payload;
// bank_* per-bank requests, one-hot accept and idle status; bank_block stops new activates;
// out_* registered command to the PHY; ref_count counts completed refreshes.
module refresh_cmd_arbiter #(
    parameter int NBANKS = 8,
    parameter int ABITS  = 17,
    parameter int BABITS = 3
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    ref_valid,
    output logic                    ref_ready,
    input  logic                    ref_last,
    input  logic [ABITS-1:0]        ref_a,
    input  logic [BABITS-1:0]       ref_ba,
    input  logic                    ref_cas,
    input  logic                    ref_ras,
    input  logic                    ref_we,
    input  logic [NBANKS-1:0]       bank_valid,
    output logic [NBANKS-1:0]       bank_ready,
    input  logic [NBANKS*ABITS-1:0] bank_a,
    input  logic [NBANKS-1:0]       bank_cas,
    input  logic [NBANKS-1:0]       bank_ras,
    input  logic [NBANKS-1:0]       bank_we,
    input  logic [NBANKS-1:0]       bank_idle,
    output logic                    bank_block,
    output logic                    out_valid,
    output logic [ABITS-1:0]        out_a,
    output logic [BABITS-1:0]       out_ba,
    output logic                    out_cas,
    output logic                    out_ras,
    output logic                    out_we,
    output logic [15:0]             ref_count
);
    localparam int PW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    typedef enum logic [1:0] {IDLE, DRAIN, REFRESH} state_t;
    state_t        state_q;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, idx;
    logic          first_q, grant;
    // Scan downward so the lowest offset from rr_ptr wins; the PW-bit add wraps modulo NBANKS.
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        for (int k = NBANKS - 1; k >= 0; k--) begin
            idx = rr_ptr_q + PW'(k);
            if (bank_valid[idx]) gnt_idx = idx;
        end
        grant      = (state_q != REFRESH) && (|bank_valid);
        rr_ptr_d   = gnt_idx + PW'(1);
        bank_ready = grant ? (NBANKS'(1) << gnt_idx) : '0;
    end
    assign bank_block = (state_q != IDLE);
    assign ref_ready  = (state_q == REFRESH) && first_q;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            first_q   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_ba    <= '0;
            out_cas   <= 1'b0;
            out_ras   <= 1'b0;
            out_we    <= 1'b0;
            ref_count <= '0;
        end else begin
            case (state_q)
                IDLE:    if (ref_valid) state_q <= DRAIN;
                DRAIN:   if ((&bank_idle) && (bank_valid == '0)) begin
                             state_q <= REFRESH;
                             first_q <= 1'b1;
                         end
                default: begin
                             first_q <= 1'b0;
                             if (ref_last) begin
                                 state_q   <= IDLE;
                                 ref_count <= ref_count + 16'd1;
                             end
                         end
            endcase
            if (grant) begin
                rr_ptr_q  <= rr_ptr_d;
                out_valid <= 1'b1;
                out_a     <= bank_a[gnt_idx*ABITS +: ABITS];
                out_ba    <= BABITS'(gnt_idx);
                out_cas   <= bank_cas[gnt_idx];
                out_ras   <= bank_ras[gnt_idx];
                out_we    <= bank_we[gnt_idx];
            end else if (state_q == REFRESH) begin
                // Payload is forwarded even for NOP cycles; only the strobe depends on the command bits.
                out_valid <= ref_cas | ref_ras | ref_we;
                out_a     <= ref_a;
                out_ba    <= ref_ba;
                out_cas   <= ref_cas;
                out_ras   <= ref_ras;
                out_we    <= ref_we;
            end else begin
                out_valid <= 1'b0;
                out_cas   <= 1'b0;
                out_ras   <= 1'b0;
                out_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_refresh_cmd_arbiter.sv
// tb_refresh_cmd_arbiter: randomized scoreboard bench for refresh_cmd_arbiter
module tb_refresh_cmd_arbiter;
    localparam int NB = 8;
    localparam int AB = 17;
    localparam int BB = 3;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ref_valid = 0, ref_ready, ref_last = 0;
    logic [AB-1:0]    ref_a = '0;
    logic [BB-1:0]    ref_ba = '0;
    logic             ref_cas = 0, ref_ras = 0, ref_we = 0;
    logic [NB-1:0]    bank_valid = '0, bank_ready, bank_cas = '0, bank_ras = '0, bank_we = '0;
    logic [NB-1:0]    bank_idle = '1;
    logic [NB*AB-1:0] bank_a = '0;
    logic             bank_block, out_valid, out_cas, out_ras, out_we;
    logic [AB-1:0]    out_a;
    logic [BB-1:0]    out_ba;
    logic [15:0]      ref_count;

    refresh_cmd_arbiter #(.NBANKS(NB), .ABITS(AB), .BABITS(BB)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_last(ref_last),
        .ref_a(ref_a), .ref_ba(ref_ba), .ref_cas(ref_cas), .ref_ras(ref_ras), .ref_we(ref_we),
        .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_a(bank_a),
        .bank_cas(bank_cas), .bank_ras(bank_ras), .bank_we(bank_we), .bank_idle(bank_idle),
        .bank_block(bank_block), .out_valid(out_valid), .out_a(out_a), .out_ba(out_ba),
        .out_cas(out_cas), .out_ras(out_ras), .out_we(out_we), .ref_count(ref_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AB-1:0] a;
        logic [BB-1:0] ba;
        logic          cas, ras, we;
        logic [15:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests = 0, fails = 0;
    // Reference model: phase 0 = idle, 1 = draining, 2 = refreshing
    int   mst = 0, mptr = 0, rk = 0;
    bit   mfirst = 0, rv_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("out_a", 32'(out_a), 32'(e.a));
            chk("out_ba", 32'(out_ba), 32'(e.ba));
            chk("out_cmd", 32'({out_cas, out_ras, out_we}), 32'({e.cas, e.ras, e.we}));
            chk("ref_count", 32'(ref_count), 32'(e.cnt));
        end
    end

    task automatic rand_banks();
        bank_valid = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
        bank_cas   = NB'($urandom);
        bank_ras   = NB'($urandom);
        bank_we    = NB'($urandom);
        bank_idle  = $urandom_range(0, 1) ? '1 : NB'($urandom);
        for (int i = 0; i < NB; i++) bank_a[i*AB +: AB] = AB'($urandom);
    endtask

    // One clock: drive refresher side, check combinational outputs, push expected register contents.
    task automatic cycle();
        int gnt;
        if (mst == 2) begin
            ref_valid = 0;
            ref_a     = (rk == 0 || rk == 3) ? AB'(1024) : AB'($urandom);
            ref_ba    = (rk == 0 || rk == 3) ? '0 : BB'($urandom);
            ref_cas   = (rk == 3);
            ref_ras   = (rk == 0 || rk == 3);
            ref_we    = (rk == 0);
            ref_last  = (rk == 11);
        end else begin
            ref_valid = rv_req;
            ref_a     = AB'($urandom);
            ref_ba    = BB'($urandom);
            {ref_cas, ref_ras, ref_we} = 3'($urandom);
            ref_last  = 0;
        end
        #1;
        gnt = -1;
        if (mst != 2)
            for (int k = 0; k < NB; k++)
                if (gnt < 0 && bank_valid[(mptr + k) % NB]) gnt = (mptr + k) % NB;
        chk("bank_ready", 32'(bank_ready), (gnt >= 0) ? (32'd1 << gnt) : 32'd0);
        chk("bank_block", 32'(bank_block), 32'(mst != 0));
        chk("ref_ready", 32'(ref_ready), 32'(mst == 2 && mfirst));
        if (gnt >= 0) begin
            cur.v = 1; cur.a = bank_a[gnt*AB +: AB]; cur.ba = BB'(gnt);
            cur.cas = bank_cas[gnt]; cur.ras = bank_ras[gnt]; cur.we = bank_we[gnt];
            mptr = (gnt + 1) % NB;
        end else if (mst == 2) begin
            cur.v = ref_cas | ref_ras | ref_we; cur.a = ref_a; cur.ba = ref_ba;
            cur.cas = ref_cas; cur.ras = ref_ras; cur.we = ref_we;
        end else begin
            cur.v = 0; cur.cas = 0; cur.ras = 0; cur.we = 0;
        end
        if (mst == 2 && ref_last) cur.cnt = cur.cnt + 16'd1;
        exp_q.push_back(cur);
        if (mst == 0) begin
            if (ref_valid) mst = 1;
        end else if (mst == 1) begin
            if (bank_idle == '1 && bank_valid == '0) begin mst = 2; mfirst = 1; rk = 0; end
        end else begin
            mfirst = 0; rk++; rv_req = 0;
            if (ref_last) mst = 0;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mst = 0; mptr = 0; rk = 0; mfirst = 0; rv_req = 0;
        cur = '{v: 0, a: '0, ba: '0, cas: 0, ras: 0, we: 0, cnt: '0};
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_bank_block", 32'(bank_block), 0);
        chk("rst_ref_ready", 32'(ref_ready), 0);
        chk("rst_bank_ready", 32'(bank_ready), 0);
        chk("rst_ref_count", 32'(ref_count), 0);
        @(negedge clk);
        rst = 0;
        // Round-robin over 0b1010_0101 from pointer 0
        bank_idle = '1;
        for (int i = 0; i < 4; i++) begin
            bank_valid = 8'hA5; bank_cas = NB'($urandom); bank_ras = NB'($urandom); bank_we = NB'($urandom);
            for (int b = 0; b < NB; b++) bank_a[b*AB +: AB] = AB'($urandom);
            cycle();
        end
        bank_valid = '0; cycle();
        // Move pointer to 6, then check wrap on 0b0000_0011
        bank_valid = 8'h20; cycle();
        bank_valid = 8'h03; cycle();
        bank_valid = 8'h03; cycle();
        bank_valid = '0; cycle();
        // Refresh request and bank 3 request in the same idle cycle
        rv_req = 1; bank_valid = 8'h08; bank_idle = 8'hF7; cycle();
        // Randomized traffic with periodic refreshes
        for (int n = 0; n < 800; n++) begin
            rand_banks();
            if (mst == 1 && $urandom_range(0, 2) == 0) begin bank_valid = '0; bank_idle = '1; end
            if (mst == 0 && !rv_req && $urandom_range(0, 19) == 0) rv_req = 1;
            cycle();
        end
        // Force a refresh, then hit it with async reset a few cycles in
        rv_req = 1;
        for (int n = 0; n < 60; n++) begin
            rand_banks();
            if (mst != 0) begin bank_valid = '0; bank_idle = '1; end
            cycle();
            if (mst == 2 && rk >= 2) break;
        end
        chk("pre_reset_block", 32'(bank_block), 1);
        #2 rst = 1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_bank_block", 32'(bank_block), 0);
        chk("arst_ref_ready", 32'(ref_ready), 0);
        chk("arst_ref_count", 32'(ref_count), 0);
        chk("arst_out_a", 32'(out_a), 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int n = 0; n < 40; n++) begin
            rand_banks();
            if (mst == 1 && $urandom_range(0, 1) == 0) begin bank_valid = '0; bank_idle = '1; end
            if (mst == 0 && !rv_req && $urandom_range(0, 9) == 0) rv_req = 1;
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/refresh_cmd_arbiter.md
# refresh_cmd_arbiter

Shares the single DRAM command slot between the refresher and NBANKS bank machines. Bank commands are served round-robin. A pending refresh blocks new bank activity, waits until every bank is closed, then grants the refresher and forwards its PRE-all/REF sequence. The block sits between the refresher/bank machines and the PHY command register.

## Interface
- NBANKS, 8, number of bank machines (power of two, ≤ 2^BABITS)
- ABITS, 17, address width
- BABITS, 3, bank address width
- sys_clk  input  1  single clock, all state on rising edge
- sys_rst  input  1  reset, asynchronous, active-high
- ref_valid  input  1  refresher requests the bus
- ref_ready  output  1  grant pulse to refresher
- ref_last  input  1  refresher sequence finished (one-cycle pulse)
- ref_a / ref_ba / ref_cas / ref_ras / ref_we  input  ABITS/BABITS/1/1/1  refresher payload; all-zero cas/ras/we = NOP
- bank_valid  input  NBANKS  per-bank command request
- bank_ready  output  NBANKS  one-hot accept, combinational
- bank_a  input  NBANKS*ABITS  bank i address at [i*ABITS +: ABITS]
- bank_cas / bank_ras / bank_we  input  NBANKS  per-bank command bits
- bank_idle  input  NBANKS  bank i has no open row
- bank_block  output  1  bank machines must not activate; they may only precharge
- out_valid  output  1  registered command strobe to PHY; no backpressure
- out_a / out_ba / out_cas / out_ras / out_we  output  ABITS/BABITS/1/1/1  registered command
- ref_count  output  16  completed refreshes, wraps at 0xFFFF→0

## Operation
- States: IDLE, DRAIN, REFRESH. Reset → IDLE.
- bank_block = (state != IDLE), decoded from the state register.
- Bank arbitration in IDLE and DRAIN:
  - Pick the first i with bank_valid[i], searching upward from rr_ptr with modulo-NBANKS wrap.
  - Assert bank_ready[i] only.
  - rr_ptr ← (i+1) mod NBANKS.
  - No grant when bank_valid = 0; rr_ptr holds.
- IDLE: ref_valid=1 → DRAIN. A bank is still granted in that same cycle.
- DRAIN: banks keep being served so they can precharge. Go to REFRESH when (&bank_idle) && (bank_valid == 0) in the same cycle. Otherwise stay.
- REFRESH:
  - bank_ready = 0.
  - ref_ready = 1 on the first REFRESH cycle only, using a first-cycle flag.
  - Every REFRESH cycle, including the first, forward the ref payload. out_valid ← (ref_cas|ref_ras|ref_we).
  - On ref_last: ref_count ← ref_count+1, then IDLE.
- Output register, every cycle:
  - Bank grant i: out_valid←1, out_a←bank i address, out_ba←i, out_cas/ras/we←bank i bits.
  - REFRESH: load as described above.
  - Otherwise out_valid←0 and out_cas/ras/we←0; out_a/out_ba hold.
- ref_valid dropping in DRAIN without a grant is illegal; behaviour is unspecified.

## Timing
- Reset values: state IDLE, rr_ptr 0, out_valid 0, out_a 0, out_ba 0, out_cas/ras/we 0, ref_count 0. Decoded outputs: bank_block 0, ref_ready 0, bank_ready 0.
- Reset asserted mid-REFRESH returns to IDLE immediately (asynchronous). The refresher shares the reset net.
- Bank path latency: bank_ready cycle t → out_valid at t+1.
- Refresh entry, all banks idle and no requests: ref_valid rises at t → DRAIN at t+1 → REFRESH at t+2 with ref_ready=1 → PRE-all appears on out at t+3.
- REFRESH payload latency: 1 cycle. At most one out_valid per cycle.
- ref_last at cycle u → IDLE at u+1. Banks are arbitrable from u+1, bank_block=0 at u+1.

## Test plan
- Round-robin: bank_valid=0b1010_0101, held for 4 cycles from rr_ptr=0 → grants 0,2,5,7 on successive cycles. out_ba=0,2,5,7 one cycle later. rr_ptr=0 afterwards.
- Wrap: rr_ptr=6, bank_valid=0b0000_0011 → grant bank 0, then bank 1. rr_ptr=2.
- Drain: ref_valid at cycle 10 with bank_idle=0xFE and bank 0 requesting a precharge → bank_block=1 from 11. Bank 0 granted at 11, bank_idle=0xFF at 12 → REFRESH at 13 with ref_ready=1.
- Refresh forwarding: real refresher with tRP=3, tRFC=8 → out shows PRE-all (ras=1, we=1, a=1024) and, 3 cycles later, REF (cas=1, ras=1, a=1024). No bank_ready during REFRESH. ref_count 0→1 one cycle after ref_last.
- Simultaneous: ref_valid and bank_valid[3] in the same IDLE cycle → bank 3 granted that cycle, state DRAIN next cycle.
- Async reset asserted mid-REFRESH → out_valid=0, bank_block=0, ref_count=0 without waiting for a clock edge.
